// File: rtl/iot_pkg.sv
// Shared definitions for the IoT device event encoder and its active-devices monitor.
package iot_pkg;
  localparam int IOT_N_DEV = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND_ON  = 2'd1,
    PEND_OFF = 2'd2
  } pend_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at N-1.
// Zero latency; no backpressure of its own, the caller decides whether to consume the grant.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  always_comb begin
    int            idx;
    logic [IW-1:0] sel;
    idx     = 0;
    sel     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!gnt_vld && req[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end
  end

endmodule

// File: rtl/iot_event_encoder.sv
// Turns per-device on/off level changes into a one-event-per-cycle stream for the monitor.
// Edge-to-change latency 2 cycles; en=0 holds events pending while edge detection continues.
module iot_event_encoder
  import iot_pkg::*;
#(
  parameter int N_DEV = IOT_N_DEV
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_DEV-1:0]         dev_status,
  input  logic                     en,
  output logic                     change,
  output logic                     on_off,
  output logic [$clog2(N_DEV)-1:0] dev_id,
  output logic                     pending
);

  localparam int IW = $clog2(N_DEV);

  logic [N_DEV-1:0] prev_status;
  logic [N_DEV-1:0] edge_det;
  logic [N_DEV-1:0] req;
  pend_state_t      state     [N_DEV];
  pend_state_t      state_nxt [N_DEV];
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_vld;
  logic             emit;

  assign edge_det = dev_status ^ prev_status;
  assign emit     = en & gnt_vld;
  assign pending  = |req;

  always_comb begin
    req = '0;
    for (int i = 0; i < N_DEV; i++) req[i] = (state[i] != IDLE);
  end

  rr_arbiter #(.N(N_DEV), .IW(IW)) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // The device being reported is seen as IDLE first, so a simultaneous edge re-arms it.
  always_comb begin
    pend_state_t cur;
    cur = IDLE;
    for (int i = 0; i < N_DEV; i++) begin
      cur = state[i];
      if (emit && gnt_idx == IW'(i)) cur = IDLE;
      state_nxt[i] = cur;
      if (edge_det[i]) begin
        if (cur != IDLE) state_nxt[i] = IDLE;
        else             state_nxt[i] = dev_status[i] ? PEND_ON : PEND_OFF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_status <= '0;
      rr_ptr      <= '0;
      change      <= 1'b0;
      on_off      <= 1'b0;
      dev_id      <= '0;
      for (int i = 0; i < N_DEV; i++) state[i] <= IDLE;
    end else begin
      prev_status <= dev_status;
      state       <= state_nxt;
      change      <= emit;
      if (emit) begin
        on_off <= (state[gnt_idx] == PEND_ON);
        dev_id <= gnt_idx;
        rr_ptr <= (gnt_idx == IW'(N_DEV - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule
